// File: rtl/nibble_serial_subtractor.sv
// Word-wide A - B built from one 4-bit subtract slice, stepped LSB nibble
// first with the carry held in a flop between steps; valid/ready on both sides.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             neg,
   output logic             ovf,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r, b_r, diff_r, diff_next;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [3:0]       a_nib, b_nib;
   logic [4:0]       sum;
   logic             last;

   // One slice of the two's-complement subtract: x + ~y + cin, carry in bit 4.
   function automatic logic [4:0] sub_nib(input logic [3:0] x, input logic [3:0] y,
                                          input logic cin);
      return {1'b0, x} + {1'b0, ~y} + {4'd0, cin};
   endfunction

   always_comb begin
      a_nib     = a_r[{idx, 2'b00} +: 4];
      b_nib     = b_r[{idx, 2'b00} +: 4];
      sum       = sub_nib(a_nib, b_nib, carry);
      last      = (idx == IW'(NIB - 1));
      diff_next = diff_r;
      diff_next[{idx, 2'b00} +: 4] = sum[3:0];
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Result flags are loaded only on the final nibble so they stay put
   // outside DONE instead of showing partial sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         diff_r <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         neg    <= 1'b1;
         ovf    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= a;
                  b_r    <= b;
                  carry  <= 1'b1;
                  idx    <= '0;
                  diff_r <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               diff_r <= diff_next;
               carry  <= sum[4];
               idx    <= idx + 1'b1;
               busy   <= !last;
               if (last) begin
                  state  <= DONE;
                  result <= {sum[4], diff_next};
                  neg    <= ~sum[4];
                  ovf    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum[3] != a_r[WIDTH-1]);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: the driver queues expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_nibble_serial_subtractor;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a_i, b_i;
   logic          out_valid, out_ready;
   logic [W:0]    result;
   logic          neg, ovf, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [W+1:0] exp_q[$];
   int           acc_q[$];
   bit           ov_prev = 0;
   bit           stream = 0;
   bit           have_prev = 0;
   int           last_rise = 0;

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .neg(neg), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [W:0] sd;
      logic [W-1:0] d;
      logic o;
      d  = x - y;
      sd = $signed({x[W-1], x}) - $signed({y[W-1], y});
      o  = (sd > 17'sd32767) || (sd < -17'sd32768);
      return {(x >= y), d, o};
   endfunction

   // Monitor: latency, spacing, invariants and scoreboard compare.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid) chk("ready_valid_exclusive", {31'd0, in_ready}, 32'd0);
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) chk("valid_without_accept", 32'd1, 32'd0);
            else chk("latency", cyc - acc_q.pop_front(), NIB + 1);
            if (stream && have_prev) chk("stream_spacing", cyc - last_rise, NIB + 2);
            have_prev = 1;
            last_rise = cyc;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {15'd0, result}, 32'd0);
            else begin
               logic [W+1:0] e;
               e = exp_q.pop_front();
               chk("result", {15'd0, result}, {15'd0, e[W+1:1]});
               chk("neg", {31'd0, neg}, {31'd0, ~e[W+1]});
               chk("ovf", {31'd0, ovf}, {31'd0, e[0]});
               chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W:0] er, input logic eo);
      int n;
      exp_q.push_back({er, eo});
      a_i = x; b_i = y; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(posedge clk);
      end
      chk("drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] x, y;
      logic [W+1:0] m;
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", {15'd0, result}, 32'd0);
      chk("rst_neg", {31'd0, neg}, 32'd1);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      send(16'h0001, 16'h0000, 17'h1_0001, 1'b0);
      send(16'h0001, 16'h0009, 17'h0_FFF8, 1'b0);
      send(16'h8000, 16'h0001, 17'h1_7FFF, 1'b1);
      send(16'h1234, 16'h1234, 17'h1_0000, 1'b0);
      drain();

      // Backpressure hold with an ignored in_valid pulse.
      out_ready = 1'b0;
      send(16'h00F0, 16'h000F, 17'h1_00E1, 1'b0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_result_hold", {15'd0, result}, 32'h1_00E1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         @(posedge clk); #1;
         in_valid = (i == 1);
         a_i = 16'h5555; b_i = 16'h1111;
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      drain();

      // Reset in the middle of RUN.
      send(16'hFFFF, 16'h0001, 17'h1_FFFE, 1'b0);
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete(); acc_q.delete(); ov_prev = 0;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", {15'd0, result}, 32'd0);
      chk("midrst_neg", {31'd0, neg}, 32'd1);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'h0003, 16'h0002, 17'h1_0001, 1'b0);
      drain();

      // Back-to-back streaming against the whole-word model.
      stream = 1; have_prev = 0;
      for (int i = 0; i < 8; i++) begin
         x = W'($urandom);
         y = (i == 3) ? x : W'($urandom);
         m = model(x, y);
         send(x, y, m[W+1:1], m[0]);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle sequencer that computes A − B for WIDTH-bit operands. It reuses one 4-bit two's-complement subtract slice (A_nib + ~B_nib + carry) across the operand nibbles, LSB nibble first, and chains the carry through a flip-flop. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It extends the existing 4-bit subtractor to wider words without replicating the adder.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+1  {carry_out, diff}, in the same format as the 4-bit subtractor's 5-bit result.
- neg  output  1  ~carry_out; unsigned A < B.
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN.

## Operation
- Three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a→A_r and b→B_r, set carry = 1 (the two's-complement +1), set idx = 0, clear diff_r, go to RUN.
- RUN:
  - Each cycle: {c, s} = A_r[idx] + ~B_r[idx] + carry (4-bit nibbles, 5-bit sum).
  - Write s to diff_r[idx], then carry ← c and idx ← idx + 1.
  - On the last nibble (idx = NIB−1), go to DONE.
  - in_ready = 0; in_valid is ignored.
- DONE:
  - out_valid = 1.
  - result = {carry, diff_r}.
  - ovf = (A_r[MSB] ≠ B_r[MSB]) & (diff_r[MSB] ≠ A_r[MSB]).
  - Outputs are held stable until out_valid & out_ready, then go to IDLE.
  - A new operand is never accepted in the same cycle as result acceptance.
- Arithmetic is modulo 2^WIDTH.
  - carry_out = 1 exactly when unsigned A ≥ B.
  - carry_out is final only after the last nibble.
- result, neg and ovf are driven from registers in every state. Outside DONE they hold their last value (zero after reset), and consumers qualify them with out_valid.
- Reset:
  - Async assertion at any time, including mid-RUN, forces IDLE immediately and clears A_r, B_r, diff_r, carry and idx.
  - The in-flight operation is discarded; no partial result is ever flagged valid.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, busy = 0.
  - result = 0, neg = 1 (carry register = 0), ovf = 0.
- Operands are accepted at edge k. busy is high after edges k+1 … k+NIB−1, and out_valid is high after edge k+NIB. Latency is NIB cycles (4 for WIDTH = 16).
- With out_ready held high, DONE lasts one cycle. The next accept can occur at the edge after IDLE is re-entered, so throughput is one operation per NIB+2 cycles.
- While out_ready = 0 in DONE, the outputs hold indefinitely and in_ready stays 0.
- in_ready and out_valid are never high in the same cycle.
- busy is a registered state decode; there are no combinational input→output paths except none (all outputs are registered or state decodes).

## Test plan
- 0x0001 − 0x0000, out_ready = 1 → out_valid 4 cycles after accept, result = 0x1_0001, neg = 0, ovf = 0; in_ready = 1 two cycles later.
- 0x0001 − 0x0009 → result = 0x0_FFF8, neg = 1, ovf = 0.
- 0x8000 − 0x0001 → result = 0x1_7FFF, ovf = 1; and 0x1234 − 0x1234 → result = 0x1_0000, neg = 0.
- Backpressure: 0x00F0 − 0x000F with out_ready = 0 for 5 cycles after out_valid → result = 0x1_00E1 stable, in_ready = 0, and an in_valid pulse during the hold is ignored. On release, out_valid drops and in_ready rises next cycle.
- Reset mid-RUN: accept 0xFFFF − 0x0001, assert rst_n = 0 after 2 RUN cycles → immediately in_ready = 1, out_valid = 0, result = 0. After release, 0x0003 − 0x0002 gives result = 0x1_0001 with normal latency.
- Back-to-back streaming of 8 random pairs with in_valid and out_ready held high → each result matches the 17-bit reference {A ≥ B, (A − B) mod 2^16}, and the spacing is 6 cycles per operation.
